slc3_mem_ctrl: RTL

Memory access sequencer between the ISDU/datapath and the off-chip 16-bit asynchronous SRAM. It converts the ISDU's level-held Mem_OE/Mem_WE requests into correctly timed, active-low SRAM strobes with a programmable wait-state count. It holds the returned read word in a register for the MDR and decodes memory-mapped I/O at address 0xFFFF: reads return the switches, and writes load the hex-display register.

---
 rtl/slc3_mem_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: SRAM access sequencer with wait states and 0xFFFF switch/hex I/O (enabled by SLC3_MEMIO_EN)
module slc3_mem_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        SRAM_Drive,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N
);
  typedef enum logic [2:0] {IDLE, RD, WR, HOLD `ifdef SLC3_MEMIO_EN , IO `endif} state_t;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  state_t state, next;
  logic [3:0] cnt;
  logic rd, wr;
`ifdef SLC3_MEMIO_EN
  logic is_wr;
`else
  assign HEX_Data = 16'h0000;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      Data_to_CPU <= 16'h0000;
      SRAM_ADDR <= 20'h00000;
      Data_to_SRAM <= 16'h0000;
`ifdef SLC3_MEMIO_EN
      HEX_Data <= 16'h0000;
      is_wr <= 1'b0;
`endif
    end else begin
      state <= next;
      cnt <= (rd || wr) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && (Mem_OE || Mem_WE)) begin
        SRAM_ADDR <= {4'h0, MAR};
        Data_to_SRAM <= MDR;
`ifdef SLC3_MEMIO_EN
        is_wr <= Mem_WE;
`endif
      end
      if (rd && cnt == LAST) Data_to_CPU <= Data_from_SRAM;
`ifdef SLC3_MEMIO_EN
      // write data was captured into Data_to_SRAM on leaving IDLE, so MDR changes cannot leak in
      if (state == IO && is_wr) HEX_Data <= Data_to_SRAM;
      if (state == IO && !is_wr) Data_to_CPU <= Switches;
`endif
    end
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
`ifdef SLC3_MEMIO_EN
        if ((Mem_WE || Mem_OE) && MAR == 16'hFFFF) next = IO;
        else
`endif
        if (Mem_WE) next = WR;
        else if (Mem_OE) next = RD;
      end
      RD, WR: next = (cnt == LAST) ? HOLD : state;
`ifdef SLC3_MEMIO_EN
      IO: next = HOLD;
`endif
      HOLD: next = (!Mem_OE && !Mem_WE) ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    rd = state == RD;
    wr = state == WR;
    CE_N = !(rd || wr);
    OE_N = !rd;
    WE_N = !wr;
    UB_N = !(rd || wr);
    LB_N = !(rd || wr);
    SRAM_Drive = wr;
`ifdef SLC3_MEMIO_EN
    Mem_Ready = ((rd || wr) && cnt == LAST) || state == IO;
`else
    Mem_Ready = (rd || wr) && cnt == LAST;
`endif
  end
endmodule
